// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A rows / B columns and streams them diagonally skewed into an N x N PE grid
//   Optional build macro SYSTOLIC_FEEDER_B_ROWS_EN: load_sel=1 beats carry a B row instead of a B column.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     load_valid/load_ready    load handshake (ready only while idle)
//     load_sel, load_idx       0 = A row idx, 1 = B column (or row) idx
//     load_data                element k at [k*DW +: DW]
//     start, start_err         stream request; error pulse if operands incomplete
//     pe_clear                 accumulator clear pulse before streaming
//     row_out, col_out         in1 / in2 edge values, lane i at [i*DW +: DW]
//     stream_valid, busy, done stream cycle flag, not-idle flag, completion pulse
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   load_sel,
    input  logic [$clog2(N)-1:0]   load_idx,
    input  logic [N*DW-1:0]        load_data,
    input  logic                   start,
    output logic                   start_err,
    output logic                   pe_clear,
    output logic [N*DW-1:0]        row_out,
    output logic [N*DW-1:0]        col_out,
    output logic                   stream_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int CW = $clog2(3*N-2);
    localparam logic [CW-1:0] LAST = CW'(3*N-3);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

    state_t          r_state, w_nstate;
    logic [CW-1:0]   r_cnt, w_ncnt;
    logic [DW-1:0]   r_a [N][N];
    logic [DW-1:0]   r_b [N][N];
    logic [N-1:0]    r_am, r_bm;
    logic            w_full, w_accept;
    logic [N*DW-1:0] w_row, w_col;

    assign w_full     = &r_am && &r_bm;
    assign load_ready = !rst && r_state == S_IDLE;
    assign w_accept   = load_valid && load_ready;
    assign busy       = r_state != S_IDLE;

    // Outputs are computed from the next state/counter so the registered
    // value for step t appears while the counter equals t.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = '0;
        w_row    = '0;
        w_col    = '0;
        case (r_state)
            S_IDLE:   w_nstate = (start && w_full) ? S_PRIME : S_IDLE;
            S_PRIME:  w_nstate = S_STREAM;
            S_STREAM: begin
                w_ncnt   = r_cnt + CW'(1);
                w_nstate = (r_cnt == LAST) ? S_DONE : S_STREAM;
            end
            default:  w_nstate = S_IDLE;
        endcase
        // Lane i carries element k at step t = i + k; B is stored as B[k][j].
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                if (w_nstate == S_STREAM && int'(w_ncnt) == i + k) begin
                    w_row[i*DW +: DW] = r_a[i][k];
                    w_col[i*DW +: DW] = r_b[k][i];
                end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_am         <= '0;
            r_bm         <= '0;
            start_err    <= 1'b0;
            pe_clear     <= 1'b0;
            stream_valid <= 1'b0;
            done         <= 1'b0;
            row_out      <= '0;
            col_out      <= '0;
        end else begin
            r_state      <= w_nstate;
            r_cnt        <= w_ncnt;
            start_err    <= r_state == S_IDLE && start && !w_full;
            pe_clear     <= w_nstate == S_PRIME;
            stream_valid <= w_nstate == S_STREAM;
            done         <= w_nstate == S_DONE;
            row_out      <= w_row;
            col_out      <= w_col;
            if (r_state == S_DONE) begin
                r_am <= '0;
                r_bm <= '0;
            end else if (w_accept) begin
                if (load_sel)
                    r_bm[load_idx] <= 1'b1;
                else
                    r_am[load_idx] <= 1'b1;
            end
        end
    end

    // Operand storage needs no reset; validity is tracked by the masks.
    always_ff @(posedge clk) begin
        if (w_accept)
            for (int k = 0; k < N; k++) begin
                if (!load_sel)
                    r_a[load_idx][k] <= load_data[k*DW +: DW];
                else
`ifdef SYSTOLIC_FEEDER_B_ROWS_EN
                    r_b[load_idx][k] <= load_data[k*DW +: DW];
`else
                    r_b[k][load_idx] <= load_data[k*DW +: DW];
`endif
            end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized + directed bench with a behavioural job model for systolic_feeder
module tb_systolic_feeder;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int W  = N*DW;
    localparam int S  = 3*N-2;
    localparam int IW = $clog2(N);

    logic          clk = 0, rst = 0, load_valid = 0, load_sel = 0, start = 0;
    logic [IW-1:0] load_idx = '0;
    logic [W-1:0]  load_data = '0;
    logic          load_ready, start_err, pe_clear, stream_valid, busy, done;
    logic [W-1:0]  row_out, col_out;

    int checks = 0, errors = 0;
    bit armed = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    bit   [N-1:0]  am = '0, bm = '0;
    int            off = 0;
    bit            eerr = 0;
    int            t_m;
    logic [W-1:0]  er, ec;

    logic [W-1:0] cap_row [S];
    logic [W-1:0] cap_col [S];
    int clr_at, done_at, err_seen, nval;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_sel(load_sel), .load_idx(load_idx), .load_data(load_data),
        .start(start), .start_err(start_err), .pe_clear(pe_clear),
        .row_out(row_out), .col_out(col_out), .stream_valid(stream_valid),
        .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Job model: off = 0 idle, 1 clear cycle, 2..3N-1 stream step off-2, 3N done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            off = 0; am = '0; bm = '0; eerr = 0;
        end else begin
            eerr = 0;
            if (off == 0) begin
                if (start) begin
                    if (&am && &bm) off = 1;
                    else eerr = 1;
                end
                if (load_valid) begin
                    for (int k = 0; k < N; k++) begin
                        if (!load_sel) ma[load_idx][k] = load_data[k*DW +: DW];
`ifdef SYSTOLIC_FEEDER_B_ROWS_EN
                        else mb[load_idx][k] = load_data[k*DW +: DW];
`else
                        else mb[k][load_idx] = load_data[k*DW +: DW];
`endif
                    end
                    if (load_sel) bm[load_idx] = 1; else am[load_idx] = 1;
                end
            end else if (off == 3*N) begin
                off = 0; am = '0; bm = '0;
            end else off++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            er = '0; ec = '0;
            t_m = off - 2;
            if (off >= 2 && off <= 3*N-1)
                for (int i = 0; i < N; i++)
                    if (t_m - i >= 0 && t_m - i < N) begin
                        er[i*DW +: DW] = ma[i][t_m-i];
                        ec[i*DW +: DW] = mb[t_m-i][i];
                    end
            chk("row_out", 64'(row_out), 64'(er));
            chk("col_out", 64'(col_out), 64'(ec));
            chk("stream_valid", 64'(stream_valid), 64'(off >= 2 && off <= 3*N-1));
            chk("pe_clear", 64'(pe_clear), 64'(off == 1));
            chk("done", 64'(done), 64'(off == 3*N));
            chk("busy", 64'(busy), 64'(off != 0));
            chk("load_ready", 64'(load_ready), 64'(off == 0 && !rst));
            chk("start_err", 64'(start_err), 64'(eerr));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic sel, input logic [IW-1:0] idx, input logic [W-1:0] d);
        load_valid = 1; load_sel = sel; load_idx = idx; load_data = d;
        step();
        load_valid = 0;
    endtask

    task automatic load_ab(input logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11);
        load(0, 0, {a01, a00});
        load(0, 1, {a11, a10});
`ifdef SYSTOLIC_FEEDER_B_ROWS_EN
        load(1, 0, {b01, b00});
        load(1, 1, {b11, b10});
`else
        load(1, 0, {b10, b00});
        load(1, 1, {b11, b01});
`endif
    endtask

    task automatic run_job(input bit noise);
        start = 1;
        step();
        start = 0;
        clr_at = -1; done_at = -1; err_seen = 0; nval = 0;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            @(negedge clk);
            if (pe_clear && clr_at < 0) clr_at = n;
            if (start_err) err_seen++;
            if (stream_valid && nval < S) begin
                cap_row[nval] = row_out; cap_col[nval] = col_out; nval++;
            end
            if (done) done_at = n;
            if (noise && n < 3*N) begin
                load_valid = 1; start = 1; load_sel = 1'($urandom);
                load_idx = IW'($urandom); load_data = W'($urandom);
            end else begin
                load_valid = 0; start = 0;
            end
        end
        load_valid = 0; start = 0;
        chk("done_latency", 64'(done_at), 64'(3*N));
        chk("clear_latency", 64'(clr_at), 64'(1));
        chk("job_start_err", 64'(err_seen), 64'(0));
        chk("stream_len", 64'(nval), 64'(S));
    endtask

    task automatic check_scn1();
        chk("t0_row", 64'(cap_row[0]), 64'h0001);
        chk("t0_col", 64'(cap_col[0]), 64'h0005);
        chk("t1_row", 64'(cap_row[1]), 64'h0302);
        chk("t1_col", 64'(cap_col[1]), 64'h0607);
        chk("t2_row", 64'(cap_row[2]), 64'h0400);
        chk("t2_col", 64'(cap_col[2]), 64'h0800);
        chk("t3_row", 64'(cap_row[3]), 64'h0000);
        chk("t3_col", 64'(cap_col[3]), 64'h0000);
    endtask

    // Behavioural PE grid: PE(i,j) sees row i delayed by j and column j delayed by i.
    task automatic check_grid(input int e00, e01, e10, e11);
        int c [N][N];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c[i][j] = 0;
                for (int s = 0; s < S; s++)
                    if (s - j >= 0 && s - i >= 0)
                        c[i][j] += int'(cap_row[s-j][i*DW +: DW]) * int'(cap_col[s-i][j*DW +: DW]);
            end
        chk("grid00", 64'(c[0][0]), 64'(e00));
        chk("grid01", 64'(c[0][1]), 64'(e01));
        chk("grid10", 64'(c[1][0]), 64'(e10));
        chk("grid11", 64'(c[1][1]), 64'(e11));
    endtask

    task automatic try_start_err();
        start = 1;
        step();
        start = 0;
        @(negedge clk);
        chk("err_pulse", 64'(start_err), 64'(1));
        chk("err_busy", 64'(busy), 64'(0));
        chk("err_clear", 64'(pe_clear), 64'(0));
        @(negedge clk);
        chk("err_one_cycle", 64'(start_err), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int dn;
        #1 rst = 1;
        armed = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(load_ready), 64'(0));
        chk("rst_rows", 64'(row_out), 64'(0));
        step();
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 64'(load_ready), 64'(1));
        step();

        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run_job(0);
        check_scn1();
        check_grid(19, 22, 43, 50);
        step();
        try_start_err();

        step();
        load(0, 0, 16'h0201);
        load(0, 1, 16'h0403);
        load(1, 0, 16'h0705);
        try_start_err();

        step();
        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run_job(1);
        check_scn1();
        check_grid(19, 22, 43, 50);

        step();
        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        start = 1;
        step();
        start = 0;
        repeat (3) @(negedge clk);
        chk("mid_t1_valid", 64'(stream_valid), 64'(1));
        chk("mid_t1_row", 64'(row_out), 64'h0302);
        #1 rst = 1;
        #1;
        chk("rst_mid_row", 64'(row_out), 64'(0));
        chk("rst_mid_col", 64'(col_out), 64'(0));
        chk("rst_mid_valid", 64'(stream_valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        step();
        rst = 0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_rst", 64'(dn), 64'(0));
        try_start_err();

        step();
        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        load(0, 0, 16'h0909);
        run_job(0);
        chk("reload_t0_row0", 64'(cap_row[0][7:0]), 64'd9);
        chk("reload_t1_row", 64'(cap_row[1]), 64'h0309);
        step();
        try_start_err();

        step();
        repeat (400) begin
            load_valid = ($urandom % 4) != 0;
            load_sel   = 1'($urandom);
            load_idx   = IW'($urandom);
            load_data  = W'($urandom);
            start      = ($urandom % 10) == 0;
            step();
        end
        load_valid = 0;
        start = 0;
        repeat (3*N+3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side driver for an N x N grid of pe_module processing elements.
- Buffers operand matrix A (rows) and matrix B (columns) from a load port.
- On start, emits diagonally skewed operand streams: row i feeds the in1 edge of array row i, column j feeds the in2 edge of array column j.
- Clears PE accumulators before streaming and flags completion when the far-corner PE has consumed its last operands.

Parameters:
- N, 4, array dimension; matrices are N x N.
- DW, 8, operand width in bits, matching pe_module in1/in2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load beat offered.
- load_ready  output  1  feeder accepts load beats.
- load_sel  input  1  0 = A row, 1 = B column.
- load_idx  input  $clog2(N)  row index (A) or column index (B).
- load_data  input  N*DW  element k at [k*DW +: DW]; A[idx][k] or B[k][idx].
- start  input  1  single-cycle request to stream.
- start_err  output  1  pulse when start is rejected.
- pe_clear  output  1  accumulator clear pulse to the whole array.
- row_out  output  N*DW  in1 edge values; row i at [i*DW +: DW].
- col_out  output  N*DW  in2 edge values; column j at [j*DW +: DW].
- stream_valid  output  1  row_out/col_out carry a stream cycle.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at completion.

Behaviour:
- Reset (async, immediate):
  - All outputs 0, state IDLE.
  - a_loaded[N-1:0] and b_loaded[N-1:0] masks cleared.
  - Buffer contents are don't-care.
- load_ready = 1 only in IDLE. A beat is accepted when load_valid && load_ready.
  - The beat writes the selected buffer line on that edge and sets the matching mask bit.
  - Reloading an index overwrites it; the mask bit stays set.
- start in IDLE:
  - If all 2N mask bits are set, go to PRIME on the next edge.
  - Otherwise start_err pulses for 1 cycle (registered, the cycle after start) and the state stays IDLE.
  - start outside IDLE is ignored and does not raise start_err.
- start and an accepted load in the same IDLE cycle: the load is written; the start check uses the masks before that load.
- PRIME (1 cycle):
  - pe_clear = 1, stream_valid = 0.
  - row_out = col_out = 0.
- STREAM (3N-2 cycles, counter t = 0..3N-3):
  - stream_valid = 1.
  - Row i = A[i][t-i] if 0 <= t-i < N, else 0.
  - Column j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Outputs are registered: the value for step t is visible during the cycle in which the counter equals t.
  - Cycles 2N-1..3N-3 are all-zero drain so operands reach PE(N-1,N-1).
- DONE (1 cycle):
  - done = 1, stream_valid = 0, outputs 0.
  - Both masks are cleared, so the next job needs a full reload.
  - Return to IDLE.
- busy = 1 in PRIME, STREAM and DONE.
- Total latency: start accepted at cycle k → pe_clear at k+1, t=0 at k+2, done at k+3N.
- rst asserted mid-STREAM: outputs zero immediately, no done pulse, masks cleared.
- Counter width is $clog2(3N-2); it must not wrap before reaching 3N-3.

Optional Feature:
- Macro SYSTOLIC_FEEDER_B_ROWS_EN.
- Defined: a load with load_sel = 1 carries B row idx, i.e. element k = B[idx][k]. Internal storage and the streaming order are unchanged, so col_out still delivers B[t-j][j].
- Undefined: load_sel = 1 carries B column idx as listed under Ports.
- Mask semantics are identical in both modes.

Test Plan:
- N=2, DW=8. Load A rows (1,2), (3,4) and B columns (5,7), (6,8), then start:
  - pe_clear pulses 1 cycle.
  - row_out/col_out per t: t0 = (1,0)/(5,0); t1 = (2,3)/(7,6); t2 = (0,4)/(0,8); t3 = (0,0)/(0,0).
  - done pulses 6 cycles after start.
  - A bench 2x2 pe_module grid ends with result = (19,22,43,50).
- Load only A plus B column 0, then start → start_err = 1 for one cycle, busy stays 0, no pe_clear.
- During STREAM, drive load_valid = 1 and start = 1 → load_ready = 0, buffers unchanged, stream completes identically, no start_err.
- Assert rst at t=1 of a stream → all outputs 0 within the reset cycle, no done. A following start without reload yields start_err.
- Load A row 0 twice ((1,2) then (9,9)) before start → t0 row 0 = 9. After done, a second start without reload yields start_err.
- Compile with SYSTOLIC_FEEDER_B_ROWS_EN, load B rows (5,6), (7,8) → identical streams and results to the first scenario.
